// File: rtl/circle_batch_scheduler.sv
// rtl/circle_batch_scheduler.sv - batch sequencer for the shared circle-point engine
// Issues one engine operation per index and queues results; issue waits for a free FIFO slot.
module circle_batch_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_k_start,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [1:0]       cmd_base_sel,
    input  logic             abort,
    output logic             eng_start,
    output logic [31:0]      eng_k,
    output logic [1:0]       eng_base_sel,
    input  logic             eng_ready,
    input  logic             eng_done,
    input  logic [31:0]      eng_x,
    input  logic [31:0]      eng_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_x,
    output logic [31:0]      out_y,
    output logic [31:0]      out_k,
    output logic             out_last,
    output logic             batch_done,
    output logic             batch_aborted,
    output logic             err_base,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t           state_q;
    logic [31:0]      k_cur_q;
    logic [CNT_W-1:0] remaining_q;
    logic [1:0]       base_q;
    logic             abort_pending_q;
    logic             eng_start_q;
    logic             batch_done_q;
    logic             batch_aborted_q;
    logic             err_base_q;

    logic [31:0]      x_mem_q    [FIFO_DEPTH];
    logic [31:0]      y_mem_q    [FIFO_DEPTH];
    logic [31:0]      k_mem_q    [FIFO_DEPTH];
    logic             last_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic abort_seen;
    logic push;
    logic pop;
    logic last_pt;
    logic fifo_free;

    assign abort_seen = abort_pending_q | abort;
    assign push       = (state_q == S_WAIT_DONE) & eng_done;
    assign pop        = out_valid & out_ready;
    assign last_pt    = (remaining_q == CNT_W'(1)) | abort_seen;
    assign fifo_free  = count_q < (PTR_W+1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            k_cur_q         <= '0;
            remaining_q     <= '0;
            base_q          <= '0;
            abort_pending_q <= 1'b0;
            eng_start_q     <= 1'b0;
            batch_done_q    <= 1'b0;
            batch_aborted_q <= 1'b0;
            err_base_q      <= 1'b0;
        end else begin
            eng_start_q     <= 1'b0;
            batch_done_q    <= 1'b0;
            batch_aborted_q <= 1'b0;
            err_base_q      <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                abort_pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        k_cur_q     <= cmd_k_start;
                        remaining_q <= cmd_count;
                        base_q      <= cmd_base_sel;
                        if (cmd_base_sel == 2'b11) begin
                            err_base_q <= 1'b1;
                        end else if (cmd_count == '0) begin
                            batch_done_q <= 1'b1;
                        end else begin
                            state_q         <= S_ISSUE;
                            abort_pending_q <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort_seen) begin
                        state_q         <= S_IDLE;
                        batch_done_q    <= 1'b1;
                        batch_aborted_q <= 1'b1;
                    end else if (eng_ready && fifo_free) begin
                        eng_start_q <= 1'b1;
                        state_q     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (eng_done) begin
                        if (last_pt) begin
                            state_q         <= S_IDLE;
                            batch_done_q    <= 1'b1;
                            // A batch that was ending on its own anyway is not reported as aborted
                            batch_aborted_q <= (remaining_q != CNT_W'(1));
                        end else begin
                            k_cur_q     <= k_cur_q + 32'd1;
                            remaining_q <= remaining_q - CNT_W'(1);
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            x_mem_q[wr_ptr_q]    <= eng_x;
            y_mem_q[wr_ptr_q]    <= eng_y;
            k_mem_q[wr_ptr_q]    <= k_cur_q;
            last_mem_q[wr_ptr_q] <= last_pt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign eng_start     = eng_start_q;
    assign eng_k         = k_cur_q;
    assign eng_base_sel  = base_q;
    assign batch_done    = batch_done_q;
    assign batch_aborted = batch_aborted_q;
    assign err_base      = err_base_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);

    // Head is forced to zero when empty so stale storage never leaks out
    assign out_valid = (count_q != '0);
    assign out_x     = out_valid ? x_mem_q[rd_ptr_q]    : 32'd0;
    assign out_y     = out_valid ? y_mem_q[rd_ptr_q]    : 32'd0;
    assign out_k     = out_valid ? k_mem_q[rd_ptr_q]    : 32'd0;
    assign out_last  = out_valid ? last_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_circle_batch_scheduler.sv
// tb/tb_circle_batch_scheduler.sv - directed self-checking bench for circle_batch_scheduler
module tb_circle_batch_scheduler;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int LAT        = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_k_start = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [1:0]       cmd_base_sel = '0;
    logic             abort = 1'b0;
    logic             eng_start;
    logic [31:0]      eng_k;
    logic [1:0]       eng_base_sel;
    logic             eng_ready;
    logic             eng_done;
    logic [31:0]      eng_x;
    logic [31:0]      eng_y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_x;
    logic [31:0]      out_y;
    logic [31:0]      out_k;
    logic             out_last;
    logic             batch_done;
    logic             batch_aborted;
    logic             err_base;
    logic             busy;

    always #5 clk = ~clk;

    circle_batch_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k_start(cmd_k_start),
        .cmd_count(cmd_count), .cmd_base_sel(cmd_base_sel), .abort(abort),
        .eng_start(eng_start), .eng_k(eng_k), .eng_base_sel(eng_base_sel),
        .eng_ready(eng_ready), .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_k(out_k), .out_last(out_last), .batch_done(batch_done),
        .batch_aborted(batch_aborted), .err_base(err_base), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // k=1 in base 2 is angle pi: cos=-1.0, sin=0 in 16.16
    function automatic logic [31:0] fx(input logic [31:0] k);
        return (k == 32'd1) ? 32'hFFFF0000 : k * 32'h00010003;
    endfunction

    function automatic logic [31:0] fy(input logic [31:0] k);
        return (k == 32'd1) ? 32'h00000000 : ~k;
    endfunction

    // Engine model: fixed latency, ready drops at start and returns one cycle after done
    int          eng_cnt;
    logic [31:0] eng_kk;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready <= 1'b1;
            eng_done  <= 1'b0;
            eng_cnt   <= 0;
            eng_kk    <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start && eng_ready) begin
                eng_ready <= 1'b0;
                eng_cnt   <= LAT;
                eng_kk    <= eng_k;
            end else if (eng_cnt > 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    eng_done <= 1'b1;
                    eng_x    <= fx(eng_kk);
                    eng_y    <= fy(eng_kk);
                end
            end else if (!eng_ready && !eng_done) begin
                eng_ready <= 1'b1;
            end
        end
    end

    logic [31:0] st_k[$];
    logic [31:0] pk[$];
    logic [31:0] px[$];
    logic [31:0] py[$];
    logic        pl[$];
    int          done_cnt = 0;
    logic        last_ab = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_start) st_k.push_back(eng_k);
            if (out_valid && out_ready) begin
                pk.push_back(out_k);
                px.push_back(out_x);
                py.push_back(out_y);
                pl.push_back(out_last);
            end
            if (batch_done) begin
                done_cnt++;
                last_ab = batch_aborted;
            end
            if (eng_done) check("eng_k_hold", eng_k, eng_kk);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        st_k.delete(); pk.delete(); px.delete(); py.delete(); pl.delete();
    endtask

    task automatic send_cmd(input logic [31:0] k, input logic [CNT_W-1:0] n, input logic [1:0] b);
        int w = 0;
        while (!cmd_ready && w < 200) begin tick(); w++; end
        check("cmd_ready_before_send", cmd_ready, 1);
        cmd_k_start  = k;
        cmd_count    = n;
        cmd_base_sel = b;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int max);
        int w = 0;
        while (done_cnt == prev && w < max) begin tick(); w++; end
        check("batch_done_seen", done_cnt > prev, 1);
    endtask

    task automatic wait_starts(input int n, input int max);
        int w = 0;
        while (st_k.size() < n && w < max) begin tick(); w++; end
        check("starts_reached", st_k.size() >= n, 1);
    endtask

    task automatic drain(input int max);
        int w = 0;
        while (out_valid && w < max) begin tick(); w++; end
        check("drained", out_valid, 0);
    endtask

    task automatic verify_pops(input logic [31:0] k0, input int n, input logic last_end);
        logic [31:0] ek;
        check("pop_count", pk.size(), n);
        for (int i = 0; i < n; i++) begin
            ek = k0 + i;
            check($sformatf("start_k[%0d]", i), st_k[i], ek);
            check($sformatf("out_k[%0d]", i), pk[i], ek);
            check($sformatf("out_x[%0d]", i), px[i], fx(ek));
            check($sformatf("out_y[%0d]", i), py[i], fy(ek));
            check($sformatf("out_last[%0d]", i), pl[i], (i == n - 1) && last_end);
        end
    endtask

    task automatic run_basic();
        int d0;
        clear_mon();
        out_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(32'd1, 16'd3, 2'b00);
        wait_done(d0, 500);
        drain(50);
        check("basic_starts", st_k.size(), 3);
        verify_pops(32'd1, 3, 1'b1);
        check("basic_x0", px[0], 32'hFFFF0000);
        check("basic_done_cnt", done_cnt - d0, 1);
        check("basic_aborted", last_ab, 0);
        check("basic_busy", busy, 0);
    endtask

    initial begin
        int d0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_batch_done", batch_done, 0);
        check("rst_eng_k", eng_k, 0);
        rst_n = 1'b1;
        tick();

        run_basic();

        // Backpressure: FIFO fills at 4, then stalls with a stable head
        clear_mon();
        out_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(32'd100, 16'd6, 2'b01);
        repeat (60) tick();
        check("bp_starts", st_k.size(), 4);
        check("bp_valid", out_valid, 1);
        check("bp_head", out_k, 32'd100);
        check("bp_base", eng_base_sel, 2'b01);
        repeat (10) tick();
        check("bp_head_stable", out_k, 32'd100);
        check("bp_starts_stable", st_k.size(), 4);
        out_ready = 1'b1;
        wait_done(d0, 500);
        drain(50);
        check("bp_starts_all", st_k.size(), 6);
        verify_pops(32'd100, 6, 1'b1);
        check("bp_aborted", last_ab, 0);

        // Degenerate commands
        clear_mon();
        d0 = done_cnt;
        send_cmd(32'd5, 16'd0, 2'b00);
        check("cnt0_done", batch_done, 1);
        check("cnt0_aborted", batch_aborted, 0);
        repeat (10) tick();
        check("cnt0_starts", st_k.size(), 0);
        check("cnt0_done_cnt", done_cnt - d0, 1);
        send_cmd(32'd5, 16'd3, 2'b11);
        check("base11_err", err_base, 1);
        check("base11_cmd_ready", cmd_ready, 1);
        repeat (10) tick();
        check("base11_starts", st_k.size(), 0);
        check("base11_err_pulse", err_base, 0);
        check("base11_busy", busy, 0);

        // Abort during the third point's WAIT_DONE
        clear_mon();
        out_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(32'd10, 16'd10, 2'b00);
        wait_starts(3, 500);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(d0, 500);
        drain(50);
        repeat (20) tick();
        check("abw_starts", st_k.size(), 3);
        verify_pops(32'd10, 3, 1'b1);
        check("abw_aborted", last_ab, 1);

        // Abort while stalled in ISSUE on a full FIFO
        clear_mon();
        out_ready = 1'b0;
        send_cmd(32'd50, 16'd10, 2'b00);
        repeat (60) tick();
        check("abi_starts_pre", st_k.size(), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abi_done", batch_done, 1);
        check("abi_aborted", batch_aborted, 1);
        out_ready = 1'b1;
        drain(50);
        repeat (10) tick();
        check("abi_starts", st_k.size(), 4);
        verify_pops(32'd50, 4, 1'b0);

        // k wraps modulo 2^32
        clear_mon();
        d0 = done_cnt;
        send_cmd(32'hFFFFFFFF, 16'd2, 2'b00);
        wait_done(d0, 500);
        drain(50);
        check("wrap_k0", st_k[0], 32'hFFFFFFFF);
        check("wrap_k1", st_k[1], 32'h00000000);
        verify_pops(32'hFFFFFFFF, 2, 1'b1);

        // Reset mid-batch with two entries queued
        clear_mon();
        out_ready = 1'b0;
        send_cmd(32'd200, 16'd6, 2'b00);
        wait_starts(3, 500);
        check("mid_valid_pre", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_eng_start", eng_start, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_basic();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
